apb_param_mem_slave: RTL and testbench
======================================

// Module: apb_param_mem_slave
// PURPOSE
//  Parametrised APB3 slave fronting a DEPTH x DATA_W synchronous register memory.
//  Adds programmable wait states, PSLVERR on out-of-range addresses and optional byte strobes.
//  Sits on the peripheral APB segment as generic scratch/config storage.
// PARAMETERS
//  DATA_W       32  data width; multiple of 8
//  ADDR_W        8  PADDR width; word address, no byte offset
//  DEPTH        16  number of words; 1 <= DEPTH <= 2**ADDR_W
//  WAIT_STATES   0  extra access-phase cycles before PREADY; 0..15
// PORTS
//  clk      in   1         clock, rising edge
//  rstn     in   1         reset, asynchronous, active-low
//  PSEL     in   1         slave select
//  PENABLE  in   1         access phase
//  PWRITE   in   1         1 = write, 0 = read
//  PADDR    in   ADDR_W    word address
//  PWDATA   in   DATA_W    write data
//  PSTRB    in   DATA_W/8  byte write strobes; present only with APB_MEM_PSTRB_EN
//  PRDATA   out  DATA_W    read data; registered
//  PREADY   out  1         transfer complete
//  PSLVERR  out  1         error response; valid only while PREADY=1
// BEHAVIOUR
//  Reset:
//   - state=IDLE, wait counter=0, PRDATA=0, PREADY=0, PSLVERR=0.
//   - All memory words cleared to 0.
//  FSM states: IDLE, ACCESS.
//  IDLE:
//   - On PSEL=1 && PENABLE=0 (setup phase): go to ACCESS and clear cnt.
//   - A read in setup phase with an in-range address issues a memory read at this edge.
//  ACCESS:
//   - PREADY = (cnt == WAIT_STATES); otherwise cnt increments each cycle.
//   - On the PREADY cycle: write commits at the clock edge (if in range), then FSM returns to IDLE.
//  Latency:
//   - WAIT_STATES=0 gives a zero-wait APB transfer (2 bus cycles) for both reads and writes.
//   - Each wait state adds 1 cycle.
//  Range check: addr_err = (PADDR >= DEPTH).
//   - PSLVERR = addr_err && PREADY.
//   - Errored writes leave memory unchanged; errored reads return PRDATA=0.
//  PRDATA:
//   - Loads at the setup edge of a read.
//   - Holds its value through wait states and after the transfer until the next read.
//  Back-to-back: a new setup phase in the cycle after PREADY is accepted from IDLE with no bubble.
//  Protocol violation (PSEL drops in ACCESS before PREADY):
//   - Return to IDLE with no write; PREADY stays 0.
//  Reset mid-transfer: asynchronous return to reset values; any pending write is lost.
//  Memory array: single port, write has priority, read data registered; no read-during-write bypass needed.
// CONFIGURATION
//  APB_MEM_PSTRB_EN defined:
//   - PSTRB port exists; byte lane i is written only if PSTRB[i]=1.
//   - PSTRB is ignored on reads.
//  APB_MEM_PSTRB_EN undefined:
//   - No PSTRB port; every write updates the full word.
// STRUCTURE
//  Package apb_mem_pkg: state_t enum {IDLE, ACCESS}; localparam for the wait counter width (4).
//  Sub-module apb_mem_array:
//   - Parameters DATA_W, DEPTH.
//   - Ports clk, rstn, wr_en, be[DATA_W/8], rd_en, addr, wdata, rdata.
//   - When APB_MEM_PSTRB_EN is undefined, the top ties be to all-ones.
//  Top contains the FSM, wait counter, range check and response logic.
// TESTING
//  1. WAIT_STATES=0: write 0xDEADBEEF to addr 3, then read addr 3.
//     -> Each PREADY comes 1 cycle after the setup phase; PRDATA=0xDEADBEEF, PSLVERR=0.
//  2. WAIT_STATES=3: read addr 0 after reset.
//     -> PREADY high on the 4th access-phase cycle; PRDATA=0x00000000.
//  3. DEPTH=16: write 0x12345678 to addr 16, then read addr 16.
//     -> PSLVERR=1 with PREADY on both; read returns 0; addr 0 is still 0.
//  4. PSTRB_EN: write 0xFFFFFFFF with PSTRB=4'b1111 to addr 5,
//     then write 0x00000000 with PSTRB=4'b0101, then read addr 5.
//     -> PRDATA=0xFF00FF00.
//  5. Back-to-back write of addr 1, then read of addr 1 with no idle cycle.
//     -> Data matches; no extra latency.
//  6. Assert rstn low during the ACCESS wait of a write to addr 2 (WAIT_STATES=2).
//     -> PREADY=0 and PRDATA=0 immediately; a later read of addr 2 returns 0.

Source files
------------

// File: rtl/apb_mem_pkg.sv
// Shared types for the APB parametrised memory slave.
package apb_mem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_W register memory: single port, byte-enabled write, registered read, cleared on reset.
module apb_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                wr_en,
    input  logic [DATA_W/8-1:0] be,
    input  logic                rd_en,
    input  logic [AW-1:0]       addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (be[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end else if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/apb_param_mem_slave.sv
// APB3 slave over a register memory with programmable wait states and PSLVERR on out-of-range addresses.
// Optional byte strobes (PSTRB port) are enabled by defining APB_MEM_PSTRB_EN.
module apb_param_mem_slave
    import apb_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic [DATA_W-1:0]   PWDATA,
`ifdef APB_MEM_PSTRB_EN
    input  logic [DATA_W/8-1:0] PSTRB,
`endif
    output logic [DATA_W-1:0]   PRDATA,
    output logic                PREADY,
    output logic                PSLVERR
);

    localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_V = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                ready_q;
    logic                err_q;
    logic                rd_zero;
    logic                addr_err;
    logic                setup;
    logic                rd_en;
    logic                wr_en;
    logic [DATA_W/8-1:0] be;
    logic [DATA_W-1:0]   rdata;

    assign addr_err = {1'b0, PADDR} >= DEPTH_V;
    assign setup    = (state == IDLE) && PSEL && !PENABLE;
    assign rd_en    = setup && !PWRITE && !addr_err;
    assign wr_en    = (state == ACCESS) && ready_q && PSEL && PWRITE && !err_q;
    assign cnt_nxt  = cnt + ONE;

`ifdef APB_MEM_PSTRB_EN
    assign be = PSTRB;
`else
    assign be = '1;
`endif

    // ready_q is precomputed one cycle ahead so PREADY comes straight from a flop
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rd_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (setup) begin
                        state   <= ACCESS;
                        cnt     <= '0;
                        ready_q <= (WAIT_V == '0);
                        err_q   <= addr_err;
                        if (!PWRITE) begin
                            rd_zero <= addr_err;
                        end
                    end
                end
                ACCESS: begin
                    if (!PSEL || ready_q) begin
                        state   <= IDLE;
                        ready_q <= 1'b0;
                    end else begin
                        cnt     <= cnt_nxt;
                        ready_q <= (cnt_nxt == WAIT_V);
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    apb_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .rstn  (rstn),
        .wr_en (wr_en),
        .be    (be),
        .rd_en (rd_en),
        .addr  (PADDR[AW-1:0]),
        .wdata (PWDATA),
        .rdata (rdata)
    );

    // an out-of-range read masks the array output until the next read
    assign PRDATA  = rd_zero ? '0 : rdata;
    assign PREADY  = ready_q;
    assign PSLVERR = ready_q && err_q;

endmodule

// File: tb/tb_apb_param_mem_slave.sv
// Bench: two slaves (0 and 3 wait states) share one APB bus and are checked against a word-array model.
module tb_apb_param_mem_slave;

    localparam int DEPTH = 16;
`ifdef APB_MEM_PSTRB_EN
    localparam bit PSTRB_EN = 1'b1;
`else
    localparam bit PSTRB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
`ifdef APB_MEM_PSTRB_EN
    logic [3:0]  pstrb;
`endif
    logic [31:0] prdata0, prdata3;
    logic        pready0, pready3;
    logic        pslverr0, pslverr3;

    int          vectors    = 0;
    int          miscompares = 0;
    logic [31:0] ref0 [DEPTH];
    logic [31:0] ref3 [DEPTH];
    logic [31:0] last0, last3;

    always #5 clk = ~clk;

    apb_param_mem_slave #(.DATA_W(32), .ADDR_W(8), .DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rstn(rstn), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_MEM_PSTRB_EN
        .PSTRB(pstrb),
`endif
        .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
    );

    apb_param_mem_slave #(.DATA_W(32), .ADDR_W(8), .DEPTH(DEPTH), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rstn(rstn), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_MEM_PSTRB_EN
        .PSTRB(pstrb),
`endif
        .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        logic [3:0]  eff;
        r   = old;
        eff = PSTRB_EN ? s : 4'hF;
        for (int b = 0; b < 4; b++) begin
            if (eff[b]) r[b*8 +: 8] = d[b*8 +: 8];
        end
        return r;
    endfunction

    task automatic drive_setup(input bit wr, input logic [7:0] a, input logic [31:0] d,
                               input logic [3:0] s);
        @(posedge clk);
        #1;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
`ifdef APB_MEM_PSTRB_EN
        pstrb   = s;
`else
        if (s === 4'hx) pwdata = d;
`endif
    endtask

    // Runs one transfer; returns per-slave PREADY cycle (1 = first access cycle) and response
    task automatic xfer(input bit wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                        output int lat0, output int lat3,
                        output logic [31:0] r0, output logic [31:0] r3,
                        output logic e0, output logic e3);
        int c;
        bit done0, done3;
        lat0 = -1; lat3 = -1; r0 = 'x; r3 = 'x; e0 = 1'bx; e3 = 1'bx;
        done0 = 1'b0; done3 = 1'b0;
        drive_setup(wr, a, d, s);
        @(posedge clk);
        #1 penable = 1'b1;
        c = 1;
        forever begin
            @(negedge clk);
            if (pready0 && !done0) begin
                done0 = 1'b1; lat0 = c; r0 = prdata0; e0 = pslverr0;
            end
            if (pready3 && !done3) begin
                done3 = 1'b1; lat3 = c; r3 = prdata3; e3 = pslverr3;
            end
            if (done0 && done3) break;
            if (c >= 40) begin
                vectors++;
                miscompares++;
                $error("FAIL pready_timeout: observed no PREADY after %0d cycles expected PREADY", c);
                break;
            end
            @(posedge clk);
            #1;
            c++;
        end
    endtask

    task automatic do_op(input bit wr, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] s, input string tag);
        int          lat0, lat3;
        logic [31:0] r0, r3, x0, x3;
        logic        e0, e3;
        bit          inr;
        xfer(wr, a, d, s, lat0, lat3, r0, r3, e0, e3);
        inr = (a < DEPTH);
        chk({tag, "_lat0"}, lat0, 1);
        chk({tag, "_lat3"}, lat3, 4);
        chk({tag, "_err0"}, e0, !inr);
        chk({tag, "_err3"}, e3, !inr);
        if (wr) begin
            chk({tag, "_hold0"}, r0, last0);
            chk({tag, "_hold3"}, r3, last3);
            if (inr) begin
                ref0[a[3:0]] = merge(ref0[a[3:0]], d, s);
                ref3[a[3:0]] = merge(ref3[a[3:0]], d, s);
            end
        end else begin
            x0 = inr ? ref0[a[3:0]] : 32'h0;
            x3 = inr ? ref3[a[3:0]] : 32'h0;
            chk({tag, "_rd0"}, r0, x0);
            chk({tag, "_rd3"}, r3, x3);
            last0 = x0;
            last3 = x3;
        end
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        bit          wr;
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  s;

        rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
`ifdef APB_MEM_PSTRB_EN
        pstrb = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            ref0[i] = '0;
            ref3[i] = '0;
        end
        last0 = '0;
        last3 = '0;

        repeat (2) @(negedge clk);
        chk("rst_pready0", pready0, 0);
        chk("rst_pready3", pready3, 0);
        chk("rst_pslverr0", pslverr0, 0);
        chk("rst_pslverr3", pslverr3, 0);
        chk("rst_prdata0", prdata0, 0);
        chk("rst_prdata3", prdata3, 0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // read after reset, then write/read, back to back
        do_op(1'b0, 8'd0, 32'h0, 4'h0, "rd0_after_rst");
        do_op(1'b1, 8'd3, 32'hDEADBEEF, 4'hF, "wr3");
        do_op(1'b0, 8'd3, 32'h0, 4'h0, "rd3");
        do_op(1'b1, 8'd1, 32'h1234ABCD, 4'hF, "b2b_wr1");
        do_op(1'b0, 8'd1, 32'h0, 4'h0, "b2b_rd1");

        // out-of-range accesses at the DEPTH boundary
        do_op(1'b1, 8'd16, 32'h12345678, 4'hF, "err_wr16");
        do_op(1'b0, 8'd16, 32'h0, 4'h0, "err_rd16");
        do_op(1'b0, 8'd0, 32'h0, 4'h0, "err_rd0");
        do_op(1'b1, 8'd15, 32'h0F0F0F0F, 4'hF, "wr15_last");
        do_op(1'b0, 8'd15, 32'h0, 4'h0, "rd15_last");
        do_op(1'b0, 8'd255, 32'h0, 4'h0, "err_rd255");

        // byte strobes
        do_op(1'b1, 8'd5, 32'hFFFFFFFF, 4'b1111, "strb_wr_a");
        do_op(1'b1, 8'd5, 32'h00000000, 4'b0101, "strb_wr_b");
        do_op(1'b0, 8'd5, 32'h0, 4'h0, "strb_rd");
        chk("strb_value", last0, PSTRB_EN ? 32'hFF00FF00 : 32'h00000000);
        go_idle();

        // PSEL dropped early: only the zero-wait slave completes the write
        drive_setup(1'b1, 8'd7, 32'hC0FFEE07, 4'hF);
        @(posedge clk);
        #1 penable = 1'b1;
        @(negedge clk);
        chk("viol_rdy0", pready0, 1);
        chk("viol_rdy3_c1", pready3, 0);
        @(posedge clk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
        @(negedge clk);
        chk("viol_rdy3_c2", pready3, 0);
        chk("viol_err3", pslverr3, 0);
        ref0[7] = 32'hC0FFEE07;
        do_op(1'b0, 8'd7, 32'h0, 4'h0, "viol_rd7");

        // reset during the wait states of a write
        do_op(1'b1, 8'd2, 32'hA5A50002, 4'hF, "prerst_wr2");
        do_op(1'b0, 8'd2, 32'h0, 4'h0, "prerst_rd2");
        drive_setup(1'b1, 8'd2, 32'h55555555, 4'hF);
        @(posedge clk);
        #1 penable = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midrst_pready0", pready0, 0);
        chk("midrst_pready3", pready3, 0);
        chk("midrst_prdata0", prdata0, 0);
        chk("midrst_prdata3", prdata3, 0);
        psel    = 1'b0;
        penable = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ref0[i] = '0;
            ref3[i] = '0;
        end
        last0 = '0;
        last3 = '0;
        @(posedge clk);
        #1 rstn = 1'b1;
        do_op(1'b0, 8'd2, 32'h0, 4'h0, "postrst_rd2");

        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, 19));
            d  = $urandom();
            s  = 4'($urandom_range(0, 15));
            do_op(wr, a, d, s, wr ? "rnd_wr" : "rnd_rd");
        end
        go_idle();
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
